// File: rtl/robo_command_issuer.sv
// robo_command_issuer
// Queues per-node manoeuvres from the path planner and replays them, one per
// node-detect rising edge, onto the 3-bit robo_command bus of the motor
// command decoder. Turns and reverses are held for a fixed number of cycles,
// after which the robot returns to forward.
// Optional build macro: WATCHDOG_EN - ends the run (with err) if no node is
// seen for WDOG_CYCLES cycles while driving forward, flushing the queue.
module robo_command_issuer #(
  parameter int DEPTH       = 8,
  parameter int TURN_CYCLES = 25000000,
  parameter int REV_CYCLES  = 50000000,
  parameter int WDOG_CYCLES = 250000000
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [2:0]               cmd_in,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     node_det,
  output logic [2:0]               robo_command,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW     = $clog2(DEPTH);
  localparam int CW     = AW + 1;
  localparam int MAX_TR = (TURN_CYCLES > REV_CYCLES) ? TURN_CYCLES : REV_CYCLES;
  localparam int MAX_C  = (MAX_TR > WDOG_CYCLES) ? MAX_TR : WDOG_CYCLES;
  localparam int TW     = $clog2(MAX_C) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FWD  = 2'd1,
    S_MAN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            node_q;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      mem_q [DEPTH];
`ifdef WATCHDOG_EN
  logic [TW-1:0]   wdog_q, wdog_d;
`endif

  logic            full_s, empty_s, push_s, cmd_ok_s, wr_s, pop_s, flush_s;
  logic            node_edge_s;
  logic [2:0]      head_s;

  // Handshake, enqueue qualification and node edge detection.
  always_comb begin
    full_s      = (count_q == CW'(DEPTH));
    empty_s     = (count_q == CW'(0));
    push_s      = cmd_valid & ~full_s;
    cmd_ok_s    = (cmd_in >= 3'd1) && (cmd_in <= 3'd4);
    wr_s        = push_s & cmd_ok_s;
    head_s      = mem_q[rd_ptr_q];
    node_edge_s = node_det & ~node_q;
  end

  // Run sequencer: next state, registered outputs, manoeuvre timer and pop.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q | (push_s & ~cmd_ok_s);
    timer_d = timer_q;
    pop_s   = 1'b0;
    flush_s = 1'b0;
`ifdef WATCHDOG_EN
    wdog_d  = TW'(0);
`endif
    case (state_q)
      S_IDLE: begin
        if (start && !empty_s) begin
          state_d = S_FWD;
          cmd_d   = 3'd1;
          busy_d  = 1'b1;
        end else begin
          cmd_d   = 3'd0;
          busy_d  = 1'b0;
        end
      end
      S_FWD: begin
        if (node_edge_s) begin
          if (empty_s) begin
            state_d = S_DONE;
            cmd_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            pop_s = 1'b1;
            case (head_s)
              3'd2, 3'd3: begin
                state_d = S_MAN;
                cmd_d   = head_s;
                timer_d = TW'(TURN_CYCLES - 1);
              end
              3'd4: begin
                state_d = S_MAN;
                cmd_d   = 3'd4;
                timer_d = TW'(REV_CYCLES - 1);
              end
              default: begin
                // forward-through: consume the node, keep driving
                state_d = S_FWD;
                cmd_d   = 3'd1;
              end
            endcase
          end
        end else begin
`ifdef WATCHDOG_EN
          if (wdog_q == TW'(WDOG_CYCLES - 1)) begin
            state_d = S_DONE;
            cmd_d   = 3'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            err_d   = 1'b1;
            flush_s = 1'b1;
          end else begin
            wdog_d  = wdog_q + TW'(1);
          end
`else
          state_d = S_FWD;
`endif
        end
      end
      S_MAN: begin
        if (timer_q == TW'(0)) begin
          state_d = S_FWD;
          cmd_d   = 3'd1;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cmd_d   = 3'd0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        cmd_d   = 3'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy update; a flush keeps only a same-cycle push.
  always_comb begin
    wr_ptr_d = wr_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    if (flush_s) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = wr_s ? CW'(1) : CW'(0);
    end else begin
      rd_ptr_d = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
      case ({wr_s, pop_s})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control and status registers with asynchronous reset.
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cmd_q    <= 3'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      timer_q  <= TW'(0);
      node_q   <= 1'b0;
      wr_ptr_q <= AW'(0);
      rd_ptr_q <= AW'(0);
      count_q  <= CW'(0);
`ifdef WATCHDOG_EN
      wdog_q   <= TW'(0);
`endif
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      timer_q  <= timer_d;
      node_q   <= node_det;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
`ifdef WATCHDOG_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  // Manoeuvre storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk_50) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= cmd_in;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign cmd_ready    = ~full_s;
  assign robo_command = cmd_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign fifo_count   = count_q;

endmodule

// File: doc/robo_command_issuer.md
Name: robo_command_issuer

Overview:
- Produces the 3-bit robo_command stream consumed by the motor command decoder.
- Holds a queue of per-node manoeuvres loaded by the path planner, then issues them in order.
- At each node-detect rising edge it pops the next manoeuvre and drives it for a timed interval, then returns to forward.
- Sits between path planner / node sensor logic and the motor command decoder.

Parameters:
- DEPTH, 8: command FIFO entries (power of 2, ≥2).
- TURN_CYCLES, 25000000: cycles a left/right command is held (0.5 s at 50 MHz); must be ≥1.
- REV_CYCLES, 50000000: cycles a reverse command is held; must be ≥1.
- WDOG_CYCLES, 250000000: node-timeout limit; used only with WATCHDOG_EN.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; one clock, asynchronous assert, active-low.
- start  in  1  single-cycle pulse that begins a run.
- cmd_in  in  3  manoeuvre to enqueue: 1 forward-through, 2 left, 3 right, 4 reverse.
- cmd_valid  in  1  cmd_in valid.
- cmd_ready  out  1  FIFO can accept; equals !full.
- node_det  in  1  node sensor level, already synchronous to clk_50.
- robo_command  out  3  to decoder: 0 idle, 1 forward, 2 left, 3 right, 4 reverse.
- busy  out  1  high in FWD or MANEUVER.
- done  out  1  one-cycle pulse at end of run.
- err  out  1  sticky error flag.
- fifo_count  out  $clog2(DEPTH)+1  entries held.

Behaviour:
- Reset (async, rst_n=0):
  - robo_command=0, busy=0, done=0, err=0, fifo_count=0.
  - FIFO pointers cleared, state=IDLE, counters=0, node edge register=0.
  - Reset mid-run aborts immediately; queued entries are lost.
- Enqueue:
  - A push occurs when cmd_valid & cmd_ready, in any state.
  - cmd_in in 1..4: written at tail; fifo_count+1 next cycle.
  - cmd_in of 0, 5, 6 or 7: handshake completes but the entry is discarded and err sets.
  - When full, cmd_ready=0 and no push happens, even if a pop occurs the same cycle.
  - Push and pop in the same cycle (not full): fifo_count unchanged.
- Node edge: node_edge = node_det & ~node_q, where node_q is node_det registered.
- Outputs are registered. robo_command changes on the clock edge after the triggering condition (1-cycle latency).
- FSM:
  - IDLE, robo_command=0:
    - start with fifo_count>0 -> FWD.
    - start with an empty FIFO is ignored.
  - FWD, robo_command=1, busy=1. On node_edge:
    - FIFO empty -> DONE.
    - Head is 1 -> pop, stay FWD.
    - Head is 2 or 3 -> pop, MANEUVER with timer=TURN_CYCLES-1.
    - Head is 4 -> pop, MANEUVER with timer=REV_CYCLES-1.
  - MANEUVER:
    - robo_command=popped value for exactly TURN_CYCLES or REV_CYCLES cycles.
    - Timer decrements each cycle; at timer==0 -> FWD.
    - node_edge is ignored (no pop).
    - start is ignored.
  - DONE:
    - robo_command=0, done=1 for one cycle, then IDLE.
    - Entries pushed after the last pop remain queued for the next start.
- start is ignored outside IDLE.
- Timer width is $clog2(max(TURN_CYCLES, REV_CYCLES, WDOG_CYCLES))+1; no wrap.
- FIFO pointers wrap modulo DEPTH.

Optional Feature:
- WATCHDOG_EN defined:
  - In FWD, a counter counts cycles since entering FWD or since the last node_edge.
  - Reaching WDOG_CYCLES -> DONE (robo_command=0, done pulse), err=1.
  - Remaining FIFO entries are flushed (fifo_count=0).
  - The counter is cleared in all other states.
- WATCHDOG_EN undefined: no counter logic; FWD waits indefinitely; WDOG_CYCLES is unused.

Test Plan (TURN_CYCLES=4, REV_CYCLES=6, DEPTH=4, WDOG_CYCLES=20):
- Reset release -> robo_command=0, cmd_ready=1, fifo_count=0. Push 2, 3, 4, 1 -> fifo_count=4, cmd_ready=0. Fifth push not accepted -> fifo_count stays 4.
- start, then node_det rising -> robo_command=2 exactly 4 cycles starting 1 cycle after edge, then 1. Two further node_det pulses during the turn -> ignored, fifo_count stays 3.
- Continue edges -> 3 for 4 cycles, 4 for 6 cycles, then a forward-through pop keeping 1. Next edge with empty FIFO -> robo_command=0, done high one cycle, busy=0.
- Push cmd_in=0 and cmd_in=7 -> fifo_count unchanged, err=1 and stays 1 until rst_n low.
- Assert rst_n=0 mid-MANEUVER (robo_command=3) -> robo_command=0 immediately without a clock edge; fifo_count=0, state IDLE.
- With WATCHDOG_EN: start with 2 queued, no node_det for 20 cycles -> done pulse, err=1, fifo_count=0, robo_command=0. Without it -> robo_command stays 1 after 100 cycles.
